// File: rtl/dcache_lsu_if.sv
// rtl/dcache_lsu_if.sv - request/response bus between dcache_lsu and dcache
//
// Signals (master = load/store unit, slave = data cache):
//   dcache_addr     master->slave  registered byte address
//   dcache_in       master->slave  store data, right-justified, masked to width
//   dcache_wordlen  master->slave  0 byte, 1 half, 2 word
//   dcache_rdreq    master->slave  read strobe, held until accepted
//   dcache_wrreq    master->slave  write strobe, held until accepted
//   dcache_busy     slave->master  cache cannot take a request this edge
//   dcache_valid    slave->master  read data valid
//   dcache_out      slave->master  read item, right-justified, zero-extended
interface dcache_lsu_if #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32
);
  logic [ADDRBITS-1:0] dcache_addr;
  logic [DATABITS-1:0] dcache_in;
  logic [1:0]          dcache_wordlen;
  logic                dcache_rdreq;
  logic                dcache_wrreq;
  logic                dcache_busy;
  logic                dcache_valid;
  logic [DATABITS-1:0] dcache_out;

  modport master (
    output dcache_addr, dcache_in, dcache_wordlen, dcache_rdreq, dcache_wrreq,
    input  dcache_busy, dcache_valid, dcache_out
  );

  modport slave (
    input  dcache_addr, dcache_in, dcache_wordlen, dcache_rdreq, dcache_wrreq,
    output dcache_busy, dcache_valid, dcache_out
  );
endinterface

// File: rtl/dcache_lsu.sv
// rtl/dcache_lsu.sv - single-outstanding RV32 load/store unit in front of dcache
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   lsu_load/lsu_store  request strobes, sampled only while lsu_ready
//   lsu_funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   lsu_addr/lsu_wdata  byte address and right-justified store data
//   lsu_rd_in           destination tag, echoed on lsu_rd_out
//   lsu_ready           high while idle
//   lsu_done            one-cycle completion pulse; lsu_err/lsu_rdata/lsu_rd_out valid with it
//   lsu_err             0 ok, 1 misaligned, 2 timeout, 3 illegal
//   dc                  cache-side bus (master modport)
module dcache_lsu #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lsu_load,
  input  logic                lsu_store,
  input  logic [2:0]          lsu_funct3,
  input  logic [ADDRBITS-1:0] lsu_addr,
  input  logic [DATABITS-1:0] lsu_wdata,
  input  logic [4:0]          lsu_rd_in,
  output logic                lsu_ready,
  output logic                lsu_done,
  output logic [1:0]          lsu_err,
  output logic [DATABITS-1:0] lsu_rdata,
  output logic [4:0]          lsu_rd_out,
  dcache_lsu_if.master        dc
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_e;

  localparam logic [9:0] TIMEOUT_CNT  = 10'(TIMEOUT);
  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  state_e              state_q, state_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] wdata_q, wdata_d;
  logic [DATABITS-1:0] rdata_q, rdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [4:0]          rd_q, rd_d;
  logic                is_load_q, is_load_d;
  logic [1:0]          err_q, err_d;
  logic [9:0]          cnt_q, cnt_d;

  logic                req_illegal;
  logic                req_misaligned;
  logic [DATABITS-1:0] wdata_masked;
  logic [DATABITS-1:0] load_ext;

  // Request classification from the live pipeline inputs (only used in IDLE).
  always_comb begin
    req_illegal = (lsu_load && lsu_store)
                || (lsu_funct3[1:0] == 2'b11)
                || (lsu_store && lsu_funct3[2])
                || (lsu_load && (lsu_funct3[2:1] == 2'b11));

    case (lsu_funct3[1:0])
      2'b01:   req_misaligned = lsu_addr[0];
      2'b10:   req_misaligned = (lsu_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase

    wdata_masked = lsu_wdata;
    case (lsu_funct3[1:0])
      2'b00: begin
        wdata_masked       = '0;
        wdata_masked[7:0]  = lsu_wdata[7:0];
      end
      2'b01: begin
        wdata_masked       = '0;
        wdata_masked[15:0] = lsu_wdata[15:0];
      end
      default: wdata_masked = lsu_wdata;
    endcase
  end

  // Extension of the returned item according to the captured funct3.
  always_comb begin
    load_ext = dc.dcache_out;
    case (funct3_q)
      3'b000:  load_ext = {{(DATABITS-8){dc.dcache_out[7]}},   dc.dcache_out[7:0]};
      3'b100:  load_ext = {{(DATABITS-8){1'b0}},               dc.dcache_out[7:0]};
      3'b001:  load_ext = {{(DATABITS-16){dc.dcache_out[15]}}, dc.dcache_out[15:0]};
      3'b101:  load_ext = {{(DATABITS-16){1'b0}},              dc.dcache_out[15:0]};
      default: load_ext = dc.dcache_out;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    is_load_d = is_load_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (lsu_load || lsu_store) begin
          addr_d    = lsu_addr;
          wdata_d   = wdata_masked;
          funct3_d  = lsu_funct3;
          rd_d      = lsu_rd_in;
          is_load_d = lsu_load;
          rdata_d   = '0;
          cnt_d     = '0;
          if (req_illegal) begin
            err_d   = ERR_ILLEGAL;
            state_d = S_DONE;
          end else if (req_misaligned) begin
            err_d   = ERR_MISALIGN;
            state_d = S_DONE;
          end else begin
            err_d   = ERR_OK;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // The strobe is a function of state only, so it and the address stay
        // stable for as long as the cache reports busy.
        if (!dc.dcache_busy) begin
          if (is_load_q) begin
            cnt_d   = '0;
            state_d = S_WAIT_RD;
          end else begin
            err_d   = ERR_OK;
            state_d = S_DONE;
          end
        end
      end

      S_WAIT_RD: begin
        // A response arriving in the same cycle the counter expires still wins.
        if (dc.dcache_valid) begin
          rdata_d = load_ext;
          err_d   = ERR_OK;
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      funct3_q  <= 3'b010;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      err_q     <= ERR_OK;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign lsu_ready         = (state_q == S_IDLE);
  assign lsu_done          = (state_q == S_DONE);
  assign lsu_err           = err_q;
  assign lsu_rdata         = rdata_q;
  assign lsu_rd_out        = rd_q;

  assign dc.dcache_addr    = addr_q;
  assign dc.dcache_in      = wdata_q;
  assign dc.dcache_wordlen = funct3_q[1:0];
  assign dc.dcache_rdreq   = (state_q == S_ISSUE) &&  is_load_q;
  assign dc.dcache_wrreq   = (state_q == S_ISSUE) && !is_load_q;

endmodule

// File: tb/tb_dcache_lsu.sv
// tb/tb_dcache_lsu.sv - randomized self-checking bench for dcache_lsu
module tb_dcache_lsu;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_load, lsu_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [4:0]  lsu_rd_in;
  logic        lsu_ready, lsu_done;
  logic [1:0]  lsu_err;
  logic [31:0] lsu_rdata;
  logic [4:0]  lsu_rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_lsu_if #(.DATABITS(DW), .ADDRBITS(AW)) dc ();

  dcache_lsu #(.DATABITS(DW), .ADDRBITS(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .lsu_load   (lsu_load),
    .lsu_store  (lsu_store),
    .lsu_funct3 (lsu_funct3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_rd_in  (lsu_rd_in),
    .lsu_ready  (lsu_ready),
    .lsu_done   (lsu_done),
    .lsu_err    (lsu_err),
    .lsu_rdata  (lsu_rdata),
    .lsu_rd_out (lsu_rd_out),
    .dc         (dc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference rules: error code of a request.
  function automatic logic [1:0] model_err(input bit ld, input bit st, input logic [2:0] f3,
                                           input logic [31:0] a);
    int size;
    if (ld && st) return 2'd3;
    if (st && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) return 2'd3;
    if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'd3;
    size = 1 << f3[1:0];
    if ((a % size) != 0) return 2'd1;
    return 2'd0;
  endfunction

  // Keep only the low bytes that an access of this width carries.
  function automatic logic [31:0] mask_width(input logic [2:0] f3, input logic [31:0] v);
    if (f3[1:0] == 2'd0) return v % 256;
    if (f3[1:0] == 2'd1) return v % 65536;
    return v;
  endfunction

  // Loaded value as the pipeline should see it, by arithmetic on the item.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] item);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = item % 256;   if (v >= 128)   v = v - 32'd256;   end
      3'd4:       v = item % 256;
      3'd1: begin v = item % 65536; if (v >= 32768) v = v - 32'd65536; end
      3'd5:       v = item % 65536;
      default:    v = item;
    endcase
    return v;
  endfunction

  // One transaction. Cycle k is the interval after edge E_k (E0 = request edge).
  // busy_n: cache busy in cycles 0..busy_n-1. vdelay: valid arrives vdelay
  // cycles after acceptance (-1 = never).
  task automatic run_txn(input string name, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input int busy_n, input int vdelay, input logic [31:0] item);
    logic [1:0]  e_err;
    logic [31:0] e_rdata, e_din;
    int          e_done, acc, rd_cnt, wr_cnt, bad, done_at;
    bit          legal;

    e_err   = model_err(ld, st, f3, addr);
    legal   = (e_err == 2'd0);
    acc     = 1 + busy_n;
    e_rdata = '0;
    e_din   = mask_width(f3, wdata);
    if (!legal)           e_done = 0;
    else if (st)          e_done = acc;
    else if (vdelay < 0)  begin e_err = 2'd2; e_done = acc + TO + 1; end
    else                  begin e_done = acc + vdelay + 1; e_rdata = model_load(f3, item); end

    @(negedge clk);
    check({name, ":ready_before"}, 32'(lsu_ready), 32'd1);
    lsu_load   = ld;
    lsu_store  = st;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wdata;
    lsu_rd_in  = rd;
    dc.dcache_busy  = 1'b0;
    dc.dcache_valid = 1'b0;
    rd_cnt = 0; wr_cnt = 0; bad = 0; done_at = -1;

    for (int k = 0; k <= e_done + 8 && done_at < 0; k++) begin
      @(negedge clk);
      lsu_load  = 1'b0;
      lsu_store = 1'b0;
      lsu_addr  = $urandom;
      lsu_wdata = $urandom;
      lsu_rd_in = 5'($urandom);
      if (k == 0) check({name, ":ready_low"}, 32'(lsu_ready), 32'd0);
      if (dc.dcache_rdreq === 1'b1) rd_cnt++;
      if (dc.dcache_wrreq === 1'b1) wr_cnt++;
      if (dc.dcache_rdreq === 1'b1 || dc.dcache_wrreq === 1'b1) begin
        if (dc.dcache_addr !== addr || dc.dcache_in !== e_din || dc.dcache_wordlen !== f3[1:0])
          bad++;
      end
      if (lsu_done === 1'b1) begin
        done_at = k;
        check({name, ":err"},    32'(lsu_err),    32'(e_err));
        check({name, ":rdata"},  lsu_rdata,       e_rdata);
        check({name, ":rd_out"}, 32'(lsu_rd_out), 32'(rd));
      end
      dc.dcache_busy = (k < busy_n);
      if (vdelay >= 0 && k == acc + vdelay) begin
        dc.dcache_valid = 1'b1;
        dc.dcache_out   = item;
      end else if (k < busy_n) begin
        dc.dcache_valid = 1'b1;        // stray response while the request is still pending
        dc.dcache_out   = $urandom;
      end else begin
        dc.dcache_valid = 1'b0;
        dc.dcache_out   = $urandom;
      end
    end

    dc.dcache_busy  = 1'b0;
    dc.dcache_valid = 1'b0;
    check({name, ":done_cycle"}, 32'(done_at), 32'(e_done));
    check({name, ":rd_strobes"}, 32'(rd_cnt), (legal && ld) ? 32'(busy_n + 1) : 32'd0);
    check({name, ":wr_strobes"}, 32'(wr_cnt), (legal && st) ? 32'(busy_n + 1) : 32'd0);
    check({name, ":bus_stable"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({name, ":done_pulse"}, 32'(lsu_done),  32'd0);
    check({name, ":ready_after"}, 32'(lsu_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, w, it;
    logic [2:0]  f3;
    int          r, bz, vd;
    bit          ld, st;

    reset = 1'b1;
    lsu_load = 1'b0; lsu_store = 1'b0; lsu_funct3 = 3'd0;
    lsu_addr = '0; lsu_wdata = '0; lsu_rd_in = '0;
    dc.dcache_busy = 1'b0; dc.dcache_valid = 1'b0; dc.dcache_out = '0;
    repeat (3) @(negedge clk);
    check("rst:ready",   32'(lsu_ready),         32'd1);
    check("rst:done",    32'(lsu_done),          32'd0);
    check("rst:err",     32'(lsu_err),           32'd0);
    check("rst:rdata",   lsu_rdata,              32'd0);
    check("rst:rd_out",  32'(lsu_rd_out),        32'd0);
    check("rst:addr",    dc.dcache_addr,         32'd0);
    check("rst:din",     dc.dcache_in,           32'd0);
    check("rst:wordlen", 32'(dc.dcache_wordlen), 32'd2);
    check("rst:rdreq",   32'(dc.dcache_rdreq),   32'd0);
    check("rst:wrreq",   32'(dc.dcache_wrreq),   32'd0);
    reset = 1'b0;

    run_txn("sw80",  0, 1, 3'd2, 32'h80, 32'h0fff0001, 5'd3,  0, 0, 32'h0);
    run_txn("lw80",  1, 0, 3'd2, 32'h80, 32'h0,        5'd7,  0, 0, 32'h0fff0001);
    run_txn("lb81",  1, 0, 3'd0, 32'h81, 32'h0,        5'd1,  0, 0, 32'h000000F0);
    run_txn("lbu81", 1, 0, 3'd4, 32'h81, 32'h0,        5'd2,  0, 0, 32'h000000F0);
    run_txn("lh82",  1, 0, 3'd1, 32'h82, 32'h0,        5'd4,  0, 0, 32'h00008001);
    run_txn("lhu82", 1, 0, 3'd5, 32'h82, 32'h0,        5'd5,  0, 0, 32'h00008001);
    run_txn("lw82",  1, 0, 3'd2, 32'h82, 32'h0,        5'd6,  0, 0, 32'h0);
    run_txn("sh81",  0, 1, 3'd1, 32'h81, 32'hBEEF,     5'd8,  0, 0, 32'h0);
    run_txn("f3_011",1, 0, 3'd3, 32'h80, 32'h0,        5'd9,  0, 0, 32'h0);
    run_txn("ld_st", 1, 1, 3'd2, 32'h80, 32'h0,        5'd10, 0, 0, 32'h0);
    run_txn("sb90b", 0, 1, 3'd0, 32'h90, 32'h1234,     5'd11, 5, 0, 32'h0);
    run_txn("tmo",   1, 0, 3'd2, 32'h40, 32'h0,        5'd12, 0, -1, 32'h0);

    // Late response after the timeout must not complete anything.
    dc.dcache_valid = 1'b1;
    dc.dcache_out   = 32'h5555AAAA;
    repeat (2) begin
      @(negedge clk);
      check("late_valid:done", 32'(lsu_done), 32'd0);
    end
    dc.dcache_valid = 1'b0;
    run_txn("lw_after_tmo", 1, 0, 3'd2, 32'h44, 32'h0, 5'd13, 1, 2, 32'hCAFEF00D);

    // Reset while waiting for read data.
    @(negedge clk);
    lsu_load = 1'b1; lsu_funct3 = 3'd2; lsu_addr = 32'h100; lsu_rd_in = 5'd21;
    @(negedge clk);
    lsu_load = 1'b0;
    @(negedge clk);
    check("mid:in_wait_ready", 32'(lsu_ready),       32'd0);
    check("mid:in_wait_rdreq", 32'(dc.dcache_rdreq), 32'd0);
    reset = 1'b1;
    dc.dcache_valid = 1'b1;
    dc.dcache_out   = 32'h0000DEAD;
    @(negedge clk);
    check("mid:ready", 32'(lsu_ready),       32'd1);
    check("mid:rdreq", 32'(dc.dcache_rdreq), 32'd0);
    check("mid:wrreq", 32'(dc.dcache_wrreq), 32'd0);
    check("mid:done",  32'(lsu_done),        32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid:no_done", 32'(lsu_done), 32'd0);
    end
    dc.dcache_valid = 1'b0;
    run_txn("lw_after_rst", 1, 0, 3'd0, 32'h103, 32'h0, 5'd22, 0, 0, 32'h00000080);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      ld = (r < 10);
      st = (r == 0) || (r >= 10);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      w  = $urandom;
      it = mask_width(f3, $urandom);
      bz = $urandom_range(0, 3);
      vd = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 4);
      run_txn($sformatf("rnd%0d", n), ld, st, f3, a, w, 5'($urandom), bz, vd, it);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
